// File: rtl/chacha20_keystream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : chacha20_keystream_ctrl_if
// Brief    : Core request/response and keystream word stream bundle.
// Revision : 1.0
// ============================================================================
interface chacha20_keystream_ctrl_if #(
    parameter int C_CNT_WIDTH = 32
);
    logic                   o_core_req;
    logic [C_CNT_WIDTH-1:0] o_core_counter;
    logic                   i_core_busy;
    logic [511:0]           i_core_keystream;
    logic                   i_core_valid;

    logic                   o_ks_tvalid;
    logic                   i_ks_tready;
    logic [31:0]            o_ks_tdata;
    logic                   o_ks_sof;

    modport master (
        output o_core_req, o_core_counter,
        input  i_core_busy, i_core_keystream, i_core_valid,
        output o_ks_tvalid, o_ks_tdata, o_ks_sof,
        input  i_ks_tready
    );

    modport slave (
        input  o_core_req, o_core_counter,
        output i_core_busy, i_core_keystream, i_core_valid,
        input  o_ks_tvalid, o_ks_tdata, o_ks_sof,
        output i_ks_tready
    );
endinterface
`default_nettype wire

// File: rtl/chacha20_keystream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chacha20_keystream_ctrl
// Brief    : Requests chacha20 blocks and serialises them into 32-bit words.
//            CHACHA20_KS_PREFETCH_EN selects a two-slot ping-pong buffer.
// Revision : 1.0
// ============================================================================
module chacha20_keystream_ctrl #(
    parameter int C_TIMEOUT_CYCLES = 255,
    parameter int C_CNT_WIDTH      = 32
) (
    input  wire logic                   s_axi_aclk,
    input  wire logic                   s_axi_aresetn,
    input  wire logic                   i_enable,
    input  wire logic                   i_key_reload,
    input  wire logic [C_CNT_WIDTH-1:0] i_counter_init,
    chacha20_keystream_ctrl_if.master   bus,
    output logic      [C_CNT_WIDTH-1:0] o_block_counter,
    output logic      [1:0]             o_status
);

`ifdef CHACHA20_KS_PREFETCH_EN
    localparam int C_NSLOT = 2;
`else
    localparam int C_NSLOT = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   req_q;
    logic [C_CNT_WIDTH-1:0] core_cnt_q;
    logic [C_CNT_WIDTH-1:0] blk_cnt_q;
    logic [1:0]             status_q;
    logic [15:0]            tmo_q;
    logic [C_NSLOT-1:0]     full_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [3:0]             word_q;
    logic [511:0]           slot_q [C_NSLOT];

    logic                   w_tvalid;
    logic                   w_hs;
    logic                   w_tmo_hit;
    logic                   w_start;
    logic                   w_capture;
    logic [511:0]           w_rd_block;

    assign w_tvalid   = full_q[rd_ptr_q];
    assign w_hs       = w_tvalid & bus.i_ks_tready;
    assign w_tmo_hit  = (tmo_q == 16'(C_TIMEOUT_CYCLES - 1));
    assign w_start    = i_enable & ~bus.i_core_busy & ~full_q[wr_ptr_q] & (status_q == 2'b00);
    assign w_capture  = (state_q == S_WAIT) & bus.i_core_valid & ~i_key_reload;
    assign w_rd_block = slot_q[rd_ptr_q];

    assign bus.o_core_req     = req_q;
    assign bus.o_core_counter = core_cnt_q;
    assign bus.o_ks_tvalid    = w_tvalid;
    assign bus.o_ks_tdata     = w_tvalid ? w_rd_block[{word_q, 5'd0} +: 32] : 32'd0;
    assign bus.o_ks_sof       = w_tvalid & (word_q == 4'd0);
    assign o_block_counter    = blk_cnt_q;
    assign o_status           = status_q;

    // Block storage carries no reset; its contents are only visible while a slot is full.
    always_ff @(posedge s_axi_aclk) begin
        if (w_capture) begin
            slot_q[wr_ptr_q] <= bus.i_core_keystream;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            core_cnt_q <= '0;
            blk_cnt_q  <= '0;
            status_q   <= 2'b00;
            tmo_q      <= 16'd0;
            full_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            word_q     <= 4'd0;
        end else if (i_key_reload) begin
            // A request already on the wire must have its response swallowed.
            state_q   <= (state_q == S_IDLE) ? S_IDLE : S_DISCARD;
            req_q     <= 1'b0;
            tmo_q     <= 16'd0;
            blk_cnt_q <= i_counter_init;
            status_q  <= 2'b00;
            full_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            word_q    <= 4'd0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        state_q    <= S_REQ;
                        req_q      <= 1'b1;
                        core_cnt_q <= blk_cnt_q;
                    end
                end
                S_REQ: begin
                    tmo_q   <= 16'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_core_valid) begin
                        full_q[wr_ptr_q] <= 1'b1;
                        if (C_NSLOT == 2) begin
                            wr_ptr_q <= ~wr_ptr_q;
                        end
                        blk_cnt_q <= blk_cnt_q + C_CNT_WIDTH'(1);
                        if (&blk_cnt_q) begin
                            status_q[1] <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        status_q[0] <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_DISCARD: begin
                    if (bus.i_core_valid || w_tmo_hit) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // The read slot never equals the slot being filled, so both updates may coexist.
            if (w_hs) begin
                word_q <= word_q + 4'd1;
                if (word_q == 4'hF) begin
                    full_q[rd_ptr_q] <= 1'b0;
                    if (C_NSLOT == 2) begin
                        rd_ptr_q <= ~rd_ptr_q;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/chacha20_keystream_ctrl.md
Name: chacha20_keystream_ctrl

Overview:
Sequences the chacha20 core for the TX and RX cipher paths. It issues block requests with an incrementing 32-bit block counter and captures each 512-bit keystream block. It then serialises each block into sixteen 32-bit words on a valid/ready stream for the XOR datapath. It also detects core timeouts and block-counter wrap, and reports them as sticky status for the AXI-Lite register slave.

Parameters:
C_TIMEOUT_CYCLES, 255, max cycles from o_core_req to i_core_valid before timeout (1..65535)
C_CNT_WIDTH, 32, block counter width (fixed 32 for RFC 8439; parameter kept for sim shortening)

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  async active-low reset
i_enable  in  1  keystream generation enable (register bit)
i_key_reload  in  1  one-cycle pulse: flush, reload counter, clear status
i_counter_init  in  C_CNT_WIDTH  counter value loaded on i_key_reload
o_core_req  out  1  one-cycle block request to chacha20
o_core_counter  out  C_CNT_WIDTH  counter for requested block, stable from req until valid
i_core_busy  in  1  core busy
i_core_keystream  in  512  keystream block
i_core_valid  in  1  one-cycle block valid
o_ks_tvalid  out  1  keystream word valid
i_ks_tready  in  1  consumer ready
o_ks_tdata  out  32  keystream word
o_ks_sof  out  1  high with word 0 of each block
o_block_counter  out  C_CNT_WIDTH  next counter to be requested
o_status  out  2  sticky: [0] core timeout, [1] counter wrap

Behaviour:
- Reset values: all outputs 0, block counter 0, buffers empty, fetch FSM in IDLE.
- Fetch FSM states: IDLE, REQ, WAIT, DISCARD.
- IDLE -> REQ when i_enable=1, i_core_busy=0, a buffer slot is free, and o_status=0.
- REQ: o_core_req=1 for exactly one cycle; timeout counter cleared; -> WAIT.
- WAIT, on i_core_valid: store block in the free slot and increment the block counter.
  - Counter was all-ones: it wraps to 0 and sets o_status[1]; no further requests until reload.
  - -> IDLE.
- WAIT, timeout: counter reaches C_TIMEOUT_CYCLES without valid -> set o_status[0], -> IDLE; no further requests until reload.
- i_key_reload in WAIT -> DISCARD. DISCARD drops the next i_core_valid or exits on timeout (no status set), then -> IDLE.
- i_key_reload in any state:
  - empties both buffers and drops o_ks_tvalid next cycle;
  - loads i_counter_init;
  - clears o_status.
- i_key_reload takes priority over a same-cycle i_core_valid or word handshake.
- i_enable=0 blocks new requests only. An outstanding WAIT completes normally and buffered words remain available.
- Output side, word order: word index i (0..15) outputs i_core_keystream[32*i+31:32*i]; o_ks_sof=1 when i=0.
- o_ks_tvalid=1 whenever the read slot is full.
- AXI-Stream rules: once asserted, tvalid/tdata/sof hold until the handshake (tvalid & tready) or a reload.
- Handshake: i advances. After i=15 the slot is freed, i resets to 0, and the read pointer toggles.
- Back-to-back: if the next slot is full, word 0 of the next block is valid the cycle after word 15 handshakes (no bubble).
- Latency: enable with empty buffer -> o_core_req 1 cycle later. i_core_valid -> o_ks_tvalid 1 cycle later.
- A simultaneous slot free (word 15 consumed) and i_core_valid into the other slot are both honoured.
- o_core_counter is registered at REQ and held until the next REQ.

Optional Feature:
CHACHA20_KS_PREFETCH_EN
- Defined: two 512-bit slots (ping-pong). The FSM requests block n+1 while block n drains, so the stream is continuous when core latency < 16 cycles.
- Undefined: single slot. A request is issued only after word 15 of the current block handshakes, leaving a gap of at least the core latency plus 2 cycles between blocks. The DISCARD state and all other behaviour are unchanged.

Test Plan:
1. Reset, i_counter_init=5, reload pulse, enable, core returns block with words 0x00000000..0x0000000F after 20 cycles, tready=1 -> o_core_counter=5, 16 words 0x0..0xF in order, sof only on word 0, o_block_counter=6.
2. PREFETCH_EN, core latency 10, tready=1 for 3 blocks -> 48 consecutive valid cycles without a bubble; counters 0,1,2 requested. Without the macro: a gap of ≥12 cycles between blocks.
3. tready toggling 1010…, tdata changed by the model mid-stall -> o_ks_tdata/tvalid stable while tready=0; no word lost or duplicated.
4. Core never asserts valid, C_TIMEOUT_CYCLES=255 -> o_status=01 after 255 cycles, no further o_core_req; reload -> o_status=00, requests resume.
5. i_counter_init=0xFFFFFFFF -> one block served, o_block_counter=0, o_status=10, no further requests.
6. Reload pulse during WAIT, then i_core_valid 3 cycles later -> block discarded, o_ks_tvalid stays 0, new request with the reloaded counter.
